fp_recip_nr: RTL and testbench
==============================

Name: fp_recip_nr

Overview:
- Sequential IEEE-754 reciprocal unit, half precision by default.
- Sits directly downstream of the X0 seed LUT and instantiates it: the operand fraction indexes X0, and the returned Q1.12 seed is refined by NITER Newton-Raphson steps, x' = x·(2 − m·x).
- Result is normalised, rounded and packed back to IEEE format.
- Used as the reciprocal stage of the FP divider and by stand-alone 1/x consumers.

Parameters:
- NEXP, 5: exponent width.
- NSIG, 11: significand width including hidden bit; fraction = NSIG−1, must equal 11 while X0 is 10-bit indexed.
- NITER, 2: Newton-Raphson iterations, 1..3.
- GUARD, 5: extra fractional bits of internal working precision; F = NSIG+GUARD.

Ports:
- clk, input, 1: clock; all state changes on rising edge.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: operand valid.
- in_ready, output, 1: unit can accept an operand.
- in_data, input, NEXP+NSIG: IEEE operand.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, NEXP+NSIG: IEEE reciprocal.
- out_flags, output, 3: {nv, dz, uf}.

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, out_data=0, out_flags=0. Reset mid-operation discards the operation; no output is produced.
- FSM: IDLE → SEED → (ITER_A → ITER_B) ×NITER → PACK → DONE → IDLE.
- in_ready=1 only in IDLE. Accept when in_valid && in_ready; capture sign, exponent E, fraction, and special class.
- SEED: register X0(fraction) as x (Q1.12 zero-extended to Q1.F); m = 1.fraction, Q1.F.
- ITER_A: t = m·x truncated to Q2.F; e = 2 − t.
- ITER_B: x = x·e truncated to Q1.F. All products are full-width before truncation; no saturation needed because x stays in (0.5,1].
- PACK:
  - fraction==0 → r = x, biased exponent Er = 2·bias − E.
  - otherwise r = 2x, Er = 2·bias − 1 − E.
  - Round r to NSIG−1 fraction bits, round-to-nearest-even. Mantissa carry to 2.0 → fraction 0, Er+1.
- Latency: out_valid rises exactly 2·NITER+2 rising edges after the accept edge (6 for defaults). Latency is fixed for all inputs, specials included.
- DONE: out_valid=1. out_data and out_flags hold stable until out_ready is seen high. That edge clears out_valid and returns to IDLE. A new operand is not accepted on the same edge.
- Specials (computed at capture; override the result in PACK, sign preserved except NaN):
  - NaN → 0x7E00 (quiet, positive), nv=1.
  - ±0 or subnormal (E=0, flushed) → ±inf, dz=1.
  - ±inf → ±0, no flags.
  - Er ≤ 0 → flush to ±0, uf=1.
- Accuracy: finite normal results lie within 1 ulp of the correctly rounded reciprocal. Exact for powers of two, since the seed is exactly 1.0 and iteration is a fixed point.
- Flags are 0 for ordinary results. out_data is don't-care-free: it always holds the last result or the reset value.

Test Plan:
- in_data=0x4000 (2.0), out_ready=1 → out_data=0x3800, flags 000, out_valid exactly 6 edges after accept.
- 0x3C00 (1.0) → 0x3C00. 0x4200 (3.0) → 0x3555 ±1 ulp. 0xC400 (−4.0) → 0xB400.
- Specials:
  - 0x8000 → 0xFC00, dz.
  - 0x0001 (subnormal) → 0x7C00, dz.
  - 0x7C00 → 0x0000.
  - 0x7E01 → 0x7E00, nv.
  - 0x7BFF (65504) → 0x0000, uf.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data/out_flags stable, in_ready=0, and in_valid pulses are ignored. out_ready=1 → IDLE next edge.
- Reset asserted during ITER_B → next edge IDLE, in_ready=1, out_valid stays 0; the following operand 0x4000 completes normally with 0x3800.
- Sweep all 2^10 fractions at E=15 against a reference model → every result within 1 ulp, flags 000, latency constant.

Source files
------------

// File: rtl/fp_recip_nr.sv
// fp_recip_nr: sequential IEEE-754 reciprocal unit (half precision by default).
// A 10-bit-indexed X0 seed table gives a Q1.12 first guess of 1/m. NITER
// Newton-Raphson steps x' = x*(2 - m*x) refine it, then the result is rounded
// to nearest-even and packed. Specials are classified at capture and replace
// the numeric result in PACK, so latency is the same for every operand.

// X0 seed table: Q1.12 approximation of 1/(1.idx), rounded to nearest.
// Entry 0 is exactly 1.0, which keeps powers of two exact through the iterations.
module fp_recip_x0 #(
    parameter int NIDX = 10
) (
    input  logic [NIDX-1:0] idx,
    output logic [12:0]     x0
);
    logic [12:0] rom [2**NIDX];

    function automatic logic [12:0] seed_val(input int i);
        int den;
        den = (1 << NIDX) + i;
        return 13'(((1 << (12 + NIDX)) + den / 2) / den);
    endfunction

    // One constant per entry; the table is a read-only lookup
    generate
        for (genvar gi = 0; gi < 2**NIDX; gi++) begin : g_rom
            assign rom[gi] = seed_val(gi);
        end
    endgenerate

    assign x0 = rom[idx];
endmodule

module fp_recip_nr #(
    parameter int NEXP  = 5,
    parameter int NSIG  = 11,
    parameter int NITER = 2,
    parameter int GUARD = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NEXP+NSIG-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEXP+NSIG-1:0] out_data,
    output logic [2:0]           out_flags
);
    localparam int F    = NSIG + GUARD;
    localparam int W    = NEXP + NSIG;
    localparam int NF   = NSIG - 1;
    localparam int BIAS = (1 << (NEXP - 1)) - 1;

    localparam logic [1:0] C_NORM = 2'd0;
    localparam logic [1:0] C_NAN  = 2'd1;
    localparam logic [1:0] C_ZERO = 2'd2;
    localparam logic [1:0] C_INF  = 2'd3;

    localparam logic [F+1:0] TWO_Q2 = {2'b10, {F{1'b0}}};

    typedef enum logic [2:0] {IDLE, SEED, ITER_A, ITER_B, PACK, DONE} state_t;
    state_t state_reg, state_next;

    logic            sign_reg;
    logic [NEXP-1:0] exp_reg;
    logic [NF-1:0]   frac_reg;
    logic [1:0]      cls_reg;
    logic [1:0]      iter_reg;
    logic [F:0]      x_reg;      // Q1.F current estimate
    logic [F+1:0]    e_reg;      // Q2.F correction factor 2 - m*x
    logic [W-1:0]    out_data_reg;
    logic [2:0]      out_flags_reg;

    logic [12:0] x0;
    fp_recip_x0 #(.NIDX(NF)) u_x0 (.idx(frac_reg), .x0(x0));

    // Newton-Raphson datapath: full-width products, then truncation
    logic [F:0]       m_val;
    logic [2*F+1:0]   prod_mx;
    logic [F+1:0]     t_val;
    logic [F+1:0]     e_next;
    logic [2*F+2:0]   prod_xe;
    logic [F:0]       x_next;

    assign m_val   = {1'b1, frac_reg, {(GUARD + 1){1'b0}}};
    assign prod_mx = (2*F+2)'(m_val) * (2*F+2)'(x_reg);
    assign t_val   = prod_mx[2*F+1:F];
    assign e_next  = TWO_Q2 - t_val;
    assign prod_xe = (2*F+3)'(x_reg) * (2*F+3)'(e_reg);
    assign x_next  = prod_xe[2*F:F];

    // Normalise, round to nearest-even and pack; specials override
    logic [F:0]    r_val;
    logic [NF-1:0] keep;
    logic          rbit, sticky, round_up;
    logic [NF:0]   mant_sum;
    int            er;
    logic [W-1:0]  res_data;
    logic [2:0]    res_flags;

    always_comb begin
        r_val     = (frac_reg == '0) ? x_reg : {x_reg[F-1:0], 1'b0};
        keep      = r_val[F-1 -: NF];
        rbit      = r_val[F-1-NF];
        sticky    = |r_val[F-2-NF:0];
        round_up  = rbit & (sticky | keep[0]);
        mant_sum  = {1'b0, keep} + {{NF{1'b0}}, round_up};
        er        = 2 * BIAS - int'(exp_reg) - ((frac_reg != '0) ? 1 : 0)
                    + (mant_sum[NF] ? 1 : 0);
        res_flags = 3'b000;
        // On a carry to 2.0 the low mantissa bits are already zero
        if (er <= 0) begin
            res_data  = {sign_reg, {(W-1){1'b0}}};
            res_flags = 3'b001;
        end else begin
            res_data  = {sign_reg, NEXP'(er), mant_sum[NF-1:0]};
        end
        case (cls_reg)
            C_NAN: begin
                res_data  = {1'b0, {NEXP{1'b1}}, 1'b1, {(NF-1){1'b0}}};
                res_flags = 3'b100;
            end
            C_ZERO: begin
                res_data  = {sign_reg, {NEXP{1'b1}}, {NF{1'b0}}};
                res_flags = 3'b010;
            end
            C_INF: begin
                res_data  = {sign_reg, {(W-1){1'b0}}};
                res_flags = 3'b000;
            end
            default: ;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{prod_mx[F-1:0], prod_xe[2*F+2:2*F+1], prod_xe[F-1:0], r_val[F]};

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = SEED;
            SEED:    state_next = ITER_A;
            ITER_A:  state_next = ITER_B;
            ITER_B:  state_next = (iter_reg == 2'(NITER - 1)) ? PACK : ITER_A;
            PACK:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk) begin
        case (state_reg)
            IDLE: if (in_valid) begin
                sign_reg <= in_data[W-1];
                exp_reg  <= in_data[W-2:NF];
                frac_reg <= in_data[NF-1:0];
                if (in_data[W-2:NF] == {NEXP{1'b1}})
                    cls_reg <= (in_data[NF-1:0] != '0) ? C_NAN : C_INF;
                else if (in_data[W-2:NF] == '0)
                    cls_reg <= C_ZERO;
                else
                    cls_reg <= C_NORM;
            end
            SEED: begin
                x_reg    <= {x0, {(F-12){1'b0}}};
                iter_reg <= 2'd0;
            end
            ITER_A: e_reg <= e_next;
            ITER_B: begin
                x_reg    <= x_next;
                iter_reg <= iter_reg + 2'd1;
            end
            default: ;
        endcase
    end

    // Result registers: loaded in PACK, held through DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_flags_reg <= '0;
        end else if (state_reg == PACK) begin
            out_data_reg  <= res_data;
            out_flags_reg <= res_flags;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_data  = out_data_reg;
    assign out_flags = out_flags_reg;
endmodule

// File: tb/tb_fp_recip_nr.sv
// Directed bench for fp_recip_nr: reset state, ordinary values, specials,
// backpressure, reset mid-operation and a full fraction sweep at E=15.
module tb_fp_recip_nr;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_flags;

    int checks = 0;
    int errors = 0;

    fp_recip_nr dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operand, wait for the result, return data/flags and latency
    task automatic do_op(input logic [15:0] d, output logic [15:0] od,
                         output logic [2:0] of, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        od = out_data;
        of = out_flags;
        $display("op in=%h out=%h flags=%b latency=%0d", d, od, of, lat);
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    logic [15:0] vin  [9] = '{16'h4000, 16'h3C00, 16'h4200, 16'hC400, 16'h8000,
                              16'h0001, 16'h7C00, 16'h7E01, 16'h7BFF};
    logic [15:0] vexp [9] = '{16'h3800, 16'h3C00, 16'h3555, 16'hB400, 16'hFC00,
                              16'h7C00, 16'h0000, 16'h7E00, 16'h0000};
    logic [2:0]  vflg [9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010,
                              3'b010, 3'b000, 3'b100, 3'b001};

    initial begin
        logic [15:0] od;
        logic [2:0]  of;
        int          lat;
        int          diff;
        int          q;
        int          seen;
        logic [15:0] expd;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",  32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data",  32'(out_data), 32'd0);
        chk("reset_out_flags", 32'(out_flags), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed values and specials (3.0 allowed within 1 ulp)
        for (int i = 0; i < 9; i++) begin
            do_op(vin[i], od, of, lat);
            chk("dir_latency", 32'(lat), 32'd6);
            diff = int'(od) - int'(vexp[i]);
            if (diff < 0) diff = -diff;
            chk("dir_data_ulp", 32'((vin[i] == 16'h4200) ? ((diff <= 1) ? 0 : diff) : diff), 32'd0);
            chk("dir_flags", 32'(of), 32'(vflg[i]));
        end

        // Backpressure: result held, input ignored for 5 cycles
        out_ready = 1'b0;
        do_op(16'h4400, od, of, lat);
        chk("bp_latency", 32'(lat), 32'd6);
        chk("bp_data", 32'(od), 32'h3400);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = 16'h3C00;
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'h3400);
            chk("bp_hold_flags", 32'(out_flags), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        do_op(16'h4000, od, of, lat);
        chk("bp_next_data", 32'(od), 32'h3800);

        // Reset asserted while in ITER_B
        in_valid = 1'b1; in_data = 16'h4200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_output", 32'(seen), 32'd0);
        do_op(16'h4000, od, of, lat);
        chk("midrst_next_data", 32'(od), 32'h3800);
        chk("midrst_next_latency", 32'(lat), 32'd6);

        // Sweep all fractions at E=15 against exact rounded 2^21/(1024+f)
        for (int f = 0; f < 1024; f++) begin
            do_op({1'b0, 5'd15, 10'(f)}, od, of, lat);
            if (f == 0) begin
                expd = 16'h3C00;
            end else begin
                q = ((1 << 21) + (1024 + f) / 2) / (1024 + f);
                expd = {1'b0, 5'd14, 10'(q)};
            end
            diff = int'(od) - int'(expd);
            if (diff < 0) diff = -diff;
            checks++;
            assert ((diff <= 1) === 1'b1) else begin
                errors++;
                $error("FAIL sweep_ulp f=%0d observed=%h expected=%h", f, od, expd);
            end
            chk("sweep_flags", 32'(of), 32'd0);
            chk("sweep_latency", 32'(lat), 32'd6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
